// File: rtl/host_mem_bridge_if.sv
// Z80 host strobes/buses and GPU RAM port for host_mem_bridge; slave = bridge side, master = host/RAM side.
// Z80_WAITn is present only when HOST_BRIDGE_WAIT_EN is defined.
interface host_mem_bridge_if #(
    parameter int ADDR_W     = 22,
    parameter int GPU_AW     = 19,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              Z80_MREQn;
    logic              Z80_M1n;
    logic              Z80_WRn;
    logic              Z80_RDn;
    logic [ADDR_W-1:0] Z80_addr;
    logic [7:0]        Z80_wData;
    logic [7:0]        Z80_rData;
    logic              Z80_rData_ena;
    logic              Z80_245data_dir;
    logic              Z80_245_oe;
    logic [GPU_AW-1:0] gpu_addr;
    logic [7:0]        gpu_wdata;
    logic              gpu_wr_ena;
    logic              gpu_wr_rdy;
    logic              gpu_rd_req;
    logic              gpu_rd_rdy;
    logic [7:0]        gpu_rData;
    logic              wr_overflow;
    logic              rd_timeout;
    logic [LVL_W-1:0]  fifo_level;
`ifdef HOST_BRIDGE_WAIT_EN
    logic              Z80_WAITn;
`endif

    modport slave (
`ifdef HOST_BRIDGE_WAIT_EN
        output Z80_WAITn,
`endif
        input  Z80_MREQn, Z80_M1n, Z80_WRn, Z80_RDn, Z80_addr, Z80_wData,
        input  gpu_rData, gpu_rd_rdy, gpu_wr_rdy,
        output gpu_addr, gpu_wdata, gpu_wr_ena, gpu_rd_req,
        output Z80_rData, Z80_rData_ena, Z80_245data_dir, Z80_245_oe,
        output wr_overflow, rd_timeout, fifo_level
    );

    modport master (
`ifdef HOST_BRIDGE_WAIT_EN
        input  Z80_WAITn,
`endif
        output Z80_MREQn, Z80_M1n, Z80_WRn, Z80_RDn, Z80_addr, Z80_wData,
        output gpu_rData, gpu_rd_rdy, gpu_wr_rdy,
        input  gpu_addr, gpu_wdata, gpu_wr_ena, gpu_rd_req,
        input  Z80_rData, Z80_rData_ena, Z80_245data_dir, Z80_245_oe,
        input  wr_overflow, rd_timeout, fifo_level
    );
endinterface

// File: rtl/host_mem_bridge.sv
// Z80 -> GPU RAM bridge: synchronised strobes, posted-write FIFO, read FSM with drain-before-read and timeout.
// Write capture SYNC_STAGES+1+SETTLE_CYCLES after WR falls; reads wait for FIFO empty, then gpu_rd_rdy or RD_TIMEOUT.
// Drain stalls on gpu_wr_rdy=0; full FIFO drops pushes (wr_overflow) unless HOST_BRIDGE_WAIT_EN adds Z80_WAITn.
module host_mem_bridge #(
    parameter int                  ADDR_W        = 22,
    parameter int                  WIN_BITS      = 3,
    parameter logic [WIN_BITS-1:0] WIN_BASE      = 3'b011,
    parameter int                  GPU_AW        = 19,
    parameter int                  SYNC_STAGES   = 2,
    parameter int                  SETTLE_CYCLES = 2,
    parameter int                  FIFO_DEPTH    = 4,
    parameter int                  RD_TIMEOUT    = 63
) (
    input  logic             GPU_CLK,
    input  logic             reset,
    host_mem_bridge_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TMO_W = $clog2(RD_TIMEOUT + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int ENT_W = GPU_AW + 8;

    typedef enum logic [2:0] {IDLE, RD_DRAIN, RD_REQ, RD_DRIVE, RD_HOLD} rd_state_t;

    logic [SYNC_STAGES-1:0] mreq_sync, m1_sync, wr_sync, rd_sync;
    logic                   wr_q, rd_q;
    logic                   mreq_s, m1_s, wr_s, rd_s;
    logic                   access, wr_fall, rd_fall, rd_rise;

    always_ff @(posedge GPU_CLK or posedge reset) begin
        if (reset) begin
            mreq_sync <= '1;
            m1_sync   <= '1;
            wr_sync   <= '1;
            rd_sync   <= '1;
            wr_q      <= 1'b1;
            rd_q      <= 1'b1;
        end else begin
            mreq_sync <= {mreq_sync[SYNC_STAGES-2:0], bus.Z80_MREQn};
            m1_sync   <= {m1_sync[SYNC_STAGES-2:0], bus.Z80_M1n};
            wr_sync   <= {wr_sync[SYNC_STAGES-2:0], bus.Z80_WRn};
            rd_sync   <= {rd_sync[SYNC_STAGES-2:0], bus.Z80_RDn};
            wr_q      <= wr_s;
            rd_q      <= rd_s;
        end
    end

    assign mreq_s  = mreq_sync[SYNC_STAGES-1];
    assign m1_s    = m1_sync[SYNC_STAGES-1];
    assign wr_s    = wr_sync[SYNC_STAGES-1];
    assign rd_s    = rd_sync[SYNC_STAGES-1];
    // Address is stable for the whole host cycle, so it is decoded unsynchronised.
    assign access  = (bus.Z80_addr[ADDR_W-1 -: WIN_BITS] == WIN_BASE) & ~mreq_s & m1_s;
    assign wr_fall = wr_q & ~wr_s;
    assign rd_fall = rd_q & ~rd_s;
    assign rd_rise = ~rd_q & rd_s;

    logic             wr_busy;
    logic [SET_W-1:0] settle_cnt;
    logic             push;

    assign push = wr_busy && (settle_cnt == SET_W'(1));

    always_ff @(posedge GPU_CLK or posedge reset) begin
        if (reset) begin
            wr_busy    <= 1'b0;
            settle_cnt <= '0;
        end else if (push) begin
            wr_busy    <= 1'b0;
        end else if (wr_fall && access) begin
            wr_busy    <= 1'b1;
            settle_cnt <= SET_W'(SETTLE_CYCLES);
        end else if (wr_busy) begin
            settle_cnt <= settle_cnt - 1'b1;
        end
    end

    logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;
    logic             full, empty, push_ok, pop, ovf;
    rd_state_t        state, nxt;

    assign full    = (level == LVL_W'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push & ~full;
    // Drain is held off in RD_REQ so gpu_addr never carries both a write and a read.
    assign pop     = ~empty & bus.gpu_wr_rdy & (state != RD_REQ);

    always_ff @(posedge GPU_CLK) begin
        if (push_ok) fifo_mem[wr_ptr] <= {bus.Z80_addr[GPU_AW-1:0], bus.Z80_wData};
    end

    always_ff @(posedge GPU_CLK or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push && full) ovf <= 1'b1;
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    logic [TMO_W-1:0]  rd_tmr;
    logic [GPU_AW-1:0] rd_addr;
    logic [7:0]        rdata;
    logic              tmo_flag;
    logic              latch_addr, ld_data, ld_tmo;
    logic              rd_req_o, drive_o, rd_oe, rd_dir_host;

    always_ff @(posedge GPU_CLK or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt         = state;
        latch_addr  = 1'b0;
        ld_data     = 1'b0;
        ld_tmo      = 1'b0;
        rd_req_o    = 1'b0;
        drive_o     = 1'b0;
        rd_oe       = 1'b0;
        rd_dir_host = 1'b0;
        case (state)
            IDLE: begin
                if (rd_fall && access) begin
                    nxt        = RD_DRAIN;
                    latch_addr = 1'b1;
                end
            end
            RD_DRAIN: begin
                // A write still settling counts as not yet drained.
                if (rd_rise)                 nxt = RD_HOLD;
                else if (empty && !wr_busy)  nxt = RD_REQ;
            end
            RD_REQ: begin
                rd_req_o    = 1'b1;
                rd_oe       = 1'b1;
                rd_dir_host = 1'b1;
                if (rd_rise) begin
                    nxt = RD_HOLD;
                end else if (bus.gpu_rd_rdy) begin
                    nxt     = RD_DRIVE;
                    ld_data = 1'b1;
                end else if (rd_tmr == TMO_W'(RD_TIMEOUT - 1)) begin
                    nxt    = RD_DRIVE;
                    ld_tmo = 1'b1;
                end
            end
            RD_DRIVE: begin
                drive_o     = 1'b1;
                rd_oe       = 1'b1;
                rd_dir_host = 1'b1;
                if (rd_rise) nxt = RD_HOLD;
            end
            RD_HOLD: begin
                rd_dir_host = 1'b1;
                nxt         = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge GPU_CLK or posedge reset) begin
        if (reset) begin
            rd_tmr   <= '0;
            rd_addr  <= '0;
            rdata    <= '0;
            tmo_flag <= 1'b0;
        end else begin
            rd_tmr <= (state == RD_REQ) ? rd_tmr + 1'b1 : '0;
            if (latch_addr) rd_addr <= bus.Z80_addr[GPU_AW-1:0];
            if (ld_data) begin
                rdata <= bus.gpu_rData;
            end else if (ld_tmo) begin
                rdata    <= 8'hFF;
                tmo_flag <= 1'b1;
            end
        end
    end

    assign bus.gpu_wr_ena      = pop;
    assign bus.gpu_rd_req      = rd_req_o;
    assign bus.gpu_addr        = rd_req_o ? rd_addr :
                                 pop      ? fifo_mem[rd_ptr][ENT_W-1:8] : '0;
    assign bus.gpu_wdata       = pop ? fifo_mem[rd_ptr][7:0] : 8'h00;
    assign bus.Z80_rData       = rdata;
    assign bus.Z80_rData_ena   = drive_o;
    assign bus.Z80_245data_dir = ~rd_dir_host;
    assign bus.Z80_245_oe      = wr_busy | rd_oe;
    assign bus.wr_overflow     = ovf;
    assign bus.rd_timeout      = tmo_flag;
    assign bus.fifo_level      = level;

`ifdef HOST_BRIDGE_WAIT_EN
    assign bus.Z80_WAITn = ~(full | (state == RD_DRAIN) | (state == RD_REQ));
`endif
endmodule

// File: tb/tb_host_mem_bridge.sv
// Directed + randomized bench for host_mem_bridge with a queue/array reference of host-visible memory.
module tb_host_mem_bridge;
    localparam int ADDR_W = 22;
    localparam int GPU_AW = 19;
    localparam int DEPTH  = 4;
    localparam int TMO    = 63;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    host_mem_bridge_if #(.ADDR_W(ADDR_W), .GPU_AW(GPU_AW), .FIFO_DEPTH(DEPTH)) bus ();

    host_mem_bridge #(.ADDR_W(ADDR_W), .GPU_AW(GPU_AW), .FIFO_DEPTH(DEPTH), .RD_TIMEOUT(TMO)) dut (
        .GPU_CLK (clk),
        .reset   (rst),
        .bus     (bus)
    );

    int          tests = 0;
    int          fails = 0;
    logic [26:0] obs_q[$];
    logic [26:0] exp_q[$];
    logic [7:0]  ram     [logic [18:0]];
    logic [7:0]  ref_mem [logic [18:0]];
    logic [18:0] ref_keys[$];
    int          cyc = 0;
    int          clash = 0;
    int          last_wr_cyc = -1;
    int          first_rd_cyc = -1;
    logic        oe_seen = 1'b0;
    logic        rdreq_seen = 1'b0;
    logic [18:0] rdreq_addr = '0;
    logic        rsp_en = 1'b0;
    int          rsp_lat = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // GPU RAM side: records write pulses, mirrors them into a RAM, flags read requests and 245 enables.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (bus.gpu_wr_ena === 1'b1) begin
            obs_q.push_back({bus.gpu_addr, bus.gpu_wdata});
            ram[bus.gpu_addr] = bus.gpu_wdata;
            last_wr_cyc = cyc;
            if (bus.gpu_rd_req === 1'b1) clash++;
        end
        if (bus.gpu_rd_req === 1'b1) begin
            if (!rdreq_seen) begin
                first_rd_cyc = cyc;
                rdreq_addr   = bus.gpu_addr;
            end
            rdreq_seen = 1'b1;
        end
        if (bus.Z80_245_oe === 1'b1) oe_seen = 1'b1;
    end

    // RAM mux read responder: one-cycle gpu_rd_rdy after rsp_lat cycles.
    initial forever begin
        logic [18:0] a;
        @(negedge clk);
        if (rsp_en && bus.gpu_rd_req === 1'b1) begin
            a = bus.gpu_addr;
            repeat (rsp_lat) @(negedge clk);
            @(posedge clk);
            #1;
            bus.gpu_rData  = ram.exists(a) ? ram[a] : 8'h00;
            bus.gpu_rd_rdy = 1'b1;
            @(posedge clk);
            #1;
            bus.gpu_rd_rdy = 1'b0;
            bus.gpu_rData  = 8'h00;
        end
    end

    task automatic host_write(input logic [21:0] a, input logic [7:0] d, input logic m1n);
        bus.Z80_addr  = a;
        bus.Z80_wData = d;
        bus.Z80_M1n   = m1n;
        bus.Z80_MREQn = 1'b0;
        tick(2);
        bus.Z80_WRn = 1'b0;
        tick(8);
        bus.Z80_WRn = 1'b1;
        tick(1);
        bus.Z80_MREQn = 1'b1;
        bus.Z80_M1n   = 1'b1;
        tick(3);
    endtask

    task automatic ref_store(input logic [21:0] a, input logic [7:0] d);
        exp_q.push_back({a[18:0], d});
        if (!ref_mem.exists(a[18:0])) ref_keys.push_back(a[18:0]);
        ref_mem[a[18:0]] = d;
    endtask

    task automatic start_read(input logic [21:0] a);
        bus.Z80_addr  = a;
        bus.Z80_M1n   = 1'b1;
        bus.Z80_MREQn = 1'b0;
        bus.Z80_RDn   = 1'b0;
    endtask

    task automatic wait_ena(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.Z80_rData_ena === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic wait_rdreq(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.gpu_rd_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic end_read();
        bus.Z80_RDn = 1'b1;
        tick(1);
        bus.Z80_MREQn = 1'b1;
        tick(4);
    endtask

    task automatic cmp_queues(input string tag);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk({tag, "_entry"}, (i < obs_q.size()) ? obs_q[i] : 27'h7FFFFFF, exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bit          ok;
        int          n;
        int          lvl;
        logic [21:0] a;
        logic [7:0]  d;
        logic [18:0] k;

        bus.Z80_MREQn  = 1'b1;
        bus.Z80_M1n    = 1'b1;
        bus.Z80_WRn    = 1'b1;
        bus.Z80_RDn    = 1'b1;
        bus.Z80_addr   = '0;
        bus.Z80_wData  = '0;
        bus.gpu_rData  = '0;
        bus.gpu_rd_rdy = 1'b0;
        bus.gpu_wr_rdy = 1'b0;

        tick(3);
        chk("rst_wr_ena", bus.gpu_wr_ena, 0);
        chk("rst_rd_req", bus.gpu_rd_req, 0);
        chk("rst_gpu_addr", bus.gpu_addr, 0);
        chk("rst_gpu_wdata", bus.gpu_wdata, 0);
        chk("rst_rdata_ena", bus.Z80_rData_ena, 0);
        chk("rst_245_oe", bus.Z80_245_oe, 0);
        chk("rst_dir", bus.Z80_245data_dir, 1);
        chk("rst_flags", {bus.wr_overflow, bus.rd_timeout}, 0);
        chk("rst_level", bus.fifo_level, 0);
        rst = 1'b0;
        tick(3);

        // Single write
        bus.gpu_wr_rdy = 1'b1;
        oe_seen = 1'b0;
        host_write(22'h180010, 8'h5A, 1'b1);
        ref_store(22'h180010, 8'h5A);
        tick(4);
        chk("single_wr_oe", oe_seen, 1);
        cmp_queues("single_wr");

        // Random posted writes, RAM always ready
        for (int i = 0; i < 10; i++) begin
            a = {3'b011, 19'($urandom)};
            d = 8'($urandom);
            host_write(a, d, 1'b1);
            ref_store(a, d);
        end
        tick(4);
        cmp_queues("rand_wr");
        chk("rand_wr_level", bus.fifo_level, 0);

        // Overflow: five writes into a stalled FIFO
        bus.gpu_wr_rdy = 1'b0;
        lvl = 0;
        for (int i = 0; i < 5; i++) begin
            a = {3'b011, 19'($urandom)};
            d = 8'($urandom);
            host_write(a, d, 1'b1);
            if (lvl < DEPTH) begin
                ref_store(a, d);
                lvl++;
            end
        end
        chk("ovf_level", bus.fifo_level, lvl);
        chk("ovf_flag", bus.wr_overflow, 1);
        chk("ovf_no_drain", obs_q.size(), 0);
        bus.gpu_wr_rdy = 1'b1;
        tick(10);
        cmp_queues("ovf_drain");

        // Read-after-write coherence
        bus.gpu_wr_rdy = 1'b0;
        host_write(22'h180020, 8'h33, 1'b1);
        ref_store(22'h180020, 8'h33);
        rdreq_seen = 1'b0;
        start_read(22'h180020);
        tick(20);
        chk("raw_req_blocked", rdreq_seen, 0);
        rsp_en = 1'b1;
        rsp_lat = 2;
        bus.gpu_wr_rdy = 1'b1;
        wait_ena(ok);
        chk("raw_ena", ok, 1);
        chk("raw_rdata", bus.Z80_rData, 8'h33);
        chk("raw_dir_host", bus.Z80_245data_dir, 0);
        chk("raw_req_after_wr", first_rd_cyc > last_wr_cyc, 1);
        chk("raw_req_addr", rdreq_addr, 19'h00020);
        end_read();
        chk("raw_dir_back", bus.Z80_245data_dir, 1);
        cmp_queues("raw_wr");

        // Random reads of previously written locations
        for (int i = 0; i < 6; i++) begin
            k = ref_keys[$urandom_range(0, ref_keys.size() - 1)];
            rsp_lat = $urandom_range(0, 5);
            start_read({3'b011, k});
            wait_ena(ok);
            chk("rand_rd_ena", ok, 1);
            chk("rand_rd_data", bus.Z80_rData, ref_mem[k]);
            end_read();
        end
        chk("rand_rd_no_tmo", bus.rd_timeout, 0);

        // Read timeout
        rsp_en = 1'b0;
        start_read(22'h192345);
        wait_rdreq(ok);
        chk("tmo_req_seen", ok, 1);
        chk("tmo_req_dir", bus.Z80_245data_dir, 0);
        chk("tmo_req_oe", bus.Z80_245_oe, 1);
        n = 0;
        while (bus.gpu_rd_req === 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        chk("tmo_req_len", n, TMO);
        wait_ena(ok);
        chk("tmo_ena", ok, 1);
        chk("tmo_rdata", bus.Z80_rData, 8'hFF);
        chk("tmo_flag", bus.rd_timeout, 1);
        end_read();
        chk("tmo_sticky", bus.rd_timeout, 1);

        // Accesses that must be ignored
        rsp_en = 1'b1;
        rsp_lat = 1;
        oe_seen = 1'b0;
        rdreq_seen = 1'b0;
        host_write(22'h080000, 8'hA5, 1'b1);
        host_write(22'h180040, 8'h77, 1'b0);
        tick(4);
        chk("ign_wr_none", obs_q.size(), 0);
        chk("ign_level", bus.fifo_level, 0);
        start_read(22'h080000);
        tick(20);
        chk("ign_rd_ena", bus.Z80_rData_ena, 0);
        end_read();
        chk("ign_rd_req", rdreq_seen, 0);
        chk("ign_oe", oe_seen, 0);

        // Reset while RD_REQ is pending
        rsp_en = 1'b0;
        start_read(22'h180010);
        wait_rdreq(ok);
        chk("rst_mid_req_seen", ok, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_rd_req", bus.gpu_rd_req, 0);
        chk("rst_mid_oe", bus.Z80_245_oe, 0);
        chk("rst_mid_dir", bus.Z80_245data_dir, 1);
        chk("rst_mid_addr", bus.gpu_addr, 0);
        chk("rst_mid_tmo", bus.rd_timeout, 0);
        bus.Z80_RDn   = 1'b1;
        bus.Z80_MREQn = 1'b1;
        tick(2);
        rst = 1'b0;
        rdreq_seen = 1'b0;
        obs_q.delete();
        tick(2);
        bus.gpu_rData  = 8'hC3;
        bus.gpu_rd_rdy = 1'b1;
        tick(1);
        bus.gpu_rd_rdy = 1'b0;
        bus.gpu_rData  = 8'h00;
        tick(20);
        chk("post_rst_no_req", rdreq_seen, 0);
        chk("post_rst_no_wr", obs_q.size(), 0);
        chk("post_rst_ena", bus.Z80_rData_ena, 0);
        chk("post_rst_rdata", bus.Z80_rData, 0);

        chk("no_addr_clash", clash, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
